// File: rtl/mem_pkg.sv
// +-----------------------------------------------------------------------------
// | mem_pkg : shared types and constants for the MEM pipeline stage
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  size;
    } exmem_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } memwb_t;

    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

    // Unknown sizes behave as words, so they need full alignment too.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] a);
        case (size)
            MEM_B, MEM_BU: return 1'b0;
            MEM_H, MEM_HU: return a[0];
            default:       return a != 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +-----------------------------------------------------------------------------
// | load_extend : picks the addressed lane of a load word and sign/zero extends
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  a_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (a_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            MEM_B:   data_o = {{24{w_byte[7]}}, w_byte};
            MEM_BU:  data_o = {24'd0, w_byte};
            MEM_H:   data_o = {{16{w_half[15]}}, w_half};
            MEM_HU:  data_o = {16'd0, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// +-----------------------------------------------------------------------------
// | mem_access_stage : EX/MEM + MEM/WB registers and req/gnt/rvalid data-bus FSM
// | Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned H/W accesses)
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int RST_PC_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RST_PC_W-1:0] ALU_result_E,
    input  logic [RST_PC_W-1:0] write_data_E,
    input  logic [4:0]          rd_E,
    input  logic                reg_write_E,
    input  logic                mem_read_E,
    input  logic                mem_write_E,
    input  logic [2:0]          mem_size_E,
    input  logic                flush_M,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [31:0]         dmem_rdata,
    output logic [RST_PC_W-1:0] ALU_result_M,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [31:0]         dmem_wdata,
    output logic [3:0]          dmem_be,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                misalign_M,
`endif
    output logic                mem_busy,
    output logic [RST_PC_W-1:0] ALU_result_W,
    output logic [RST_PC_W-1:0] read_data_W,
    output logic [4:0]          rd_W,
    output logic                reg_write_W,
    output logic                mem_to_reg_W
);

    exmem_t     exmem_q, exmem_d;
    memwb_t     memwb_q;
    mem_state_t state_q;

    logic        w_is_mem_q;
    logic        w_we;
    logic [1:0]  w_a;
    logic        w_in_mem;
    logic        w_misalign_in;
    logic        w_start;
    logic [31:0] w_load_data;

    assign w_is_mem_q = exmem_q.mem_read | exmem_q.mem_write;
    assign w_we       = exmem_q.mem_write & ~exmem_q.mem_read;
    assign w_a        = exmem_q.alu[1:0];
    assign w_in_mem   = (mem_read_E | mem_write_E) & ~flush_M;
    assign w_start    = w_in_mem & ~w_misalign_in;

    always_comb begin
        exmem_d = EXMEM_BUBBLE;
        if (!flush_M) begin
            exmem_d.alu       = ALU_result_E;
            exmem_d.wdata     = write_data_E;
            exmem_d.rd        = rd_E;
            exmem_d.reg_write = reg_write_E;
            exmem_d.mem_read  = mem_read_E;
            exmem_d.mem_write = mem_write_E;
            exmem_d.size      = mem_size_E;
        end
    end

    assign mem_busy = ((state_q == ST_REQ) & ~(dmem_gnt & w_we))
                    | ((state_q == ST_WAIT) & ~dmem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_q <= EXMEM_BUBBLE;
            memwb_q <= MEMWB_BUBBLE;
            state_q <= ST_IDLE;
        end else begin
            if (!mem_busy) begin
                exmem_q <= exmem_d;
                state_q <= w_start ? ST_REQ : ST_IDLE;
            end else if (state_q == ST_REQ && dmem_gnt) begin
                state_q <= ST_WAIT;
            end

            // Mem ops only retire into MEM/WB on their bus handshake.
            if (state_q == ST_REQ && dmem_gnt && w_we) begin
                memwb_q.alu        <= exmem_q.alu;
                memwb_q.rdata      <= 32'd0;
                memwb_q.rd         <= exmem_q.rd;
                memwb_q.reg_write  <= 1'b0;
                memwb_q.mem_to_reg <= 1'b0;
            end else if (state_q == ST_WAIT && dmem_rvalid) begin
                memwb_q.alu        <= exmem_q.alu;
                memwb_q.rdata      <= w_load_data;
                memwb_q.rd         <= exmem_q.rd;
                memwb_q.reg_write  <= exmem_q.reg_write;
                memwb_q.mem_to_reg <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                if (w_is_mem_q) begin
                    memwb_q <= MEMWB_BUBBLE;
                end else begin
                    memwb_q.alu        <= exmem_q.alu;
                    memwb_q.rdata      <= 32'd0;
                    memwb_q.rd         <= exmem_q.rd;
                    memwb_q.reg_write  <= exmem_q.reg_write;
                    memwb_q.mem_to_reg <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        case (exmem_q.size)
            MEM_B, MEM_BU: begin
                dmem_be    = 4'b0001 << w_a;
                dmem_wdata = {4{exmem_q.wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                dmem_be    = w_a[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{exmem_q.wdata[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = exmem_q.wdata;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata_i (dmem_rdata),
        .a_i     (w_a),
        .size_i  (exmem_q.size),
        .data_o  (w_load_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign w_misalign_in = is_misaligned(mem_size_E, ALU_result_E[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= ~mem_busy & w_in_mem & w_misalign_in;
        end
    end

    assign misalign_M = misalign_q;
`else
    assign w_misalign_in = 1'b0;
`endif

    assign ALU_result_M = exmem_q.alu;
    assign dmem_req     = (state_q == ST_REQ);
    assign dmem_we      = w_we;
    assign dmem_addr    = {exmem_q.alu[ADDR_W-1:2], 2'b00};
    assign ALU_result_W = memwb_q.alu;
    assign read_data_W  = memwb_q.rdata;
    assign rd_W         = memwb_q.rd;
    assign reg_write_W  = memwb_q.reg_write;
    assign mem_to_reg_W = memwb_q.mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// +-----------------------------------------------------------------------------
// | tb_mem_access_stage : directed vector table plus multi-cycle corner sequences
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALU_result_E, write_data_E, dmem_rdata;
    logic [4:0]  rd_E;
    logic        reg_write_E, mem_read_E, mem_write_E, flush_M, dmem_gnt, dmem_rvalid;
    logic [2:0]  mem_size_E;
    logic [31:0] ALU_result_M, dmem_addr, dmem_wdata, ALU_result_W, read_data_W;
    logic        dmem_req, dmem_we, mem_busy, reg_write_W, mem_to_reg_W;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_W;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_M;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALU_result_E (ALU_result_E),
        .write_data_E (write_data_E),
        .rd_E         (rd_E),
        .reg_write_E  (reg_write_E),
        .mem_read_E   (mem_read_E),
        .mem_write_E  (mem_write_E),
        .mem_size_E   (mem_size_E),
        .flush_M      (flush_M),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .ALU_result_M (ALU_result_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_M   (misalign_M),
`endif
        .mem_busy     (mem_busy),
        .ALU_result_W (ALU_result_W),
        .read_data_W  (read_data_W),
        .rd_W         (rd_W),
        .reg_write_W  (reg_write_W),
        .mem_to_reg_W (mem_to_reg_W)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  size;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] rdw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw, input logic [2:0] size);
        ALU_result_E = alu;
        write_data_E = wd;
        rd_E         = rd;
        reg_write_E  = rw;
        mem_read_E   = mr;
        mem_write_E  = mw;
        mem_size_E   = size;
    endtask

    task automatic nop();
        drive_e(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, MEM_W);
    endtask

    // One instruction through EX/MEM and MEM/WB, gnt on first REQ cycle, rvalid next.
    task automatic run_vec(input vec_t v, input string nm);
        drive_e(v.alu, v.wd, v.rd, v.rw, v.mr, v.mw, v.size);
        tick();
        nop();
        #1;
        chk({nm, " alu_M"}, ALU_result_M, v.alu);
        if (v.mr || v.mw) begin
            chk({nm, " req"}, {31'd0, dmem_req}, 32'd1);
            chk({nm, " we"}, {31'd0, dmem_we}, {31'd0, v.mw & ~v.mr});
            chk({nm, " addr"}, dmem_addr, v.addr);
            chk({nm, " be"}, {28'd0, dmem_be}, {28'd0, v.be});
            chk({nm, " wdata"}, dmem_wdata, v.wdata);
            dmem_gnt = 1'b1;
            #1;
            chk({nm, " busy@gnt"}, {31'd0, mem_busy}, {31'd0, v.mr});
            tick();
            dmem_gnt = 1'b0;
            if (v.mr) begin
                #1;
                chk({nm, " busy@wait"}, {31'd0, mem_busy}, 32'd1);
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                #1;
                chk({nm, " busy@rvalid"}, {31'd0, mem_busy}, 32'd0);
                tick();
                dmem_rvalid = 1'b0;
                #1;
                chk({nm, " rdata_W"}, read_data_W, v.rdw);
                chk({nm, " m2r_W"}, {31'd0, mem_to_reg_W}, 32'd1);
                chk({nm, " rw_W"}, {31'd0, reg_write_W}, {31'd0, v.rw});
            end else begin
                #1;
                chk({nm, " m2r_W"}, {31'd0, mem_to_reg_W}, 32'd0);
                chk({nm, " rw_W"}, {31'd0, reg_write_W}, 32'd0);
            end
        end else begin
            chk({nm, " req"}, {31'd0, dmem_req}, 32'd0);
            chk({nm, " busy"}, {31'd0, mem_busy}, 32'd0);
            tick();
            #1;
            chk({nm, " m2r_W"}, {31'd0, mem_to_reg_W}, 32'd0);
            chk({nm, " rw_W"}, {31'd0, reg_write_W}, {31'd0, v.rw});
        end
        chk({nm, " alu_W"}, ALU_result_W, v.alu);
        chk({nm, " rd_W"}, {27'd0, rd_W}, {27'd0, v.rd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        vec_t mis;

        //            alu           wd            rd     rw    mr    mw    size     rdata         be       wdata         addr          rdw
        vecs[0]  = '{32'h0000_1234, 32'h0,        5'd5,  1'b1, 1'b0, 1'b0, MEM_W,  32'h0,        4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{32'h0000_0103, 32'h0000_00AB, 5'd1, 1'b1, 1'b0, 1'b1, MEM_B,  32'h0,        4'b1000, 32'hABAB_ABAB, 32'h0000_0100, 32'h0};
        vecs[2]  = '{32'h0000_0102, 32'h1234_BEEF, 5'd2, 1'b0, 1'b0, 1'b1, MEM_H,  32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0000_0100, 32'h0};
        vecs[3]  = '{32'h0000_0204, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 1'b1, MEM_W,  32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0000_0204, 32'h0};
        vecs[4]  = '{32'h0000_0102, 32'h0,        5'd7,  1'b1, 1'b1, 1'b0, MEM_B,  32'h0080_0000, 4'b0100, 32'h0,        32'h0000_0100, 32'hFFFF_FF80};
        vecs[5]  = '{32'h0000_0102, 32'h0,        5'd7,  1'b1, 1'b1, 1'b0, MEM_BU, 32'h0080_0000, 4'b0100, 32'h0,        32'h0000_0100, 32'h0000_0080};
        vecs[6]  = '{32'h0000_0106, 32'h0,        5'd8,  1'b1, 1'b1, 1'b0, MEM_H,  32'h8001_7FFF, 4'b1100, 32'h0,        32'h0000_0104, 32'hFFFF_8001};
        vecs[7]  = '{32'h0000_0104, 32'h0,        5'd9,  1'b1, 1'b1, 1'b0, MEM_HU, 32'h8001_F00D, 4'b0011, 32'h0,        32'h0000_0104, 32'h0000_F00D};
        vecs[8]  = '{32'h0000_0208, 32'h0,        5'd11, 1'b1, 1'b1, 1'b0, MEM_W,  32'hCAFE_F00D, 4'b1111, 32'h0,        32'h0000_0208, 32'hCAFE_F00D};
        vecs[9]  = '{32'h0000_0101, 32'h0,        5'd12, 1'b1, 1'b1, 1'b0, MEM_B,  32'h1234_7F00, 4'b0010, 32'h0,        32'h0000_0100, 32'h0000_007F};
        vecs[10] = '{32'h0000_0300, 32'h1122_3344, 5'd13, 1'b0, 1'b0, 1'b1, 3'b011, 32'h0,        4'b1111, 32'h1122_3344, 32'h0000_0300, 32'h0};
        vecs[11] = '{32'h0000_020C, 32'h7777_7777, 5'd10, 1'b1, 1'b1, 1'b1, MEM_W,  32'h0BAD_F00D, 4'b1111, 32'h7777_7777, 32'h0000_020C, 32'h0BAD_F00D};

        rst_n = 1'b0;
        flush_M = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0;
        drive_e(32'h5555_5555, 32'h1, 5'd3, 1'b1, 1'b1, 1'b0, MEM_W);
        tick();
        tick();
        chk("rst req", {31'd0, dmem_req}, 32'd0);
        chk("rst busy", {31'd0, mem_busy}, 32'd0);
        chk("rst alu_M", ALU_result_M, 32'd0);
        chk("rst alu_W", ALU_result_W, 32'd0);
        chk("rst rw_W", {31'd0, reg_write_W}, 32'd0);
        nop();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Slow LB with a flush arriving while busy.
        drive_e(32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, MEM_B);
        tick();
        drive_e(32'h0000_0999, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, MEM_W);
        flush_M = 1'b1;
        dmem_rdata = 32'h0080_0000;
        busy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            dmem_gnt = (c == 2);
            dmem_rvalid = (c == 5);
            #1;
            if (mem_busy) busy_cnt++;
            if (c < 5) chk($sformatf("slow hold c%0d", c), ALU_result_M, 32'h0000_0102);
            chk($sformatf("slow req c%0d", c), {31'd0, dmem_req}, {31'd0, c < 3});
            tick();
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        chk("slow busy cycles", busy_cnt, 32'd5);
        chk("slow rdata_W", read_data_W, 32'hFFFF_FF80);
        chk("flush bubble alu_M", ALU_result_M, 32'd0);
        chk("flush bubble req", {31'd0, dmem_req}, 32'd0);
        flush_M = 1'b0;
        nop();
        tick();
        #1;
        chk("flush bubble rw_W", {31'd0, reg_write_W}, 32'd0);
        chk("flush bubble alu_W", ALU_result_W, 32'd0);

        // Back-to-back SW then LW with no idle cycle between.
        drive_e(32'h0000_0040, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b1, MEM_W);
        tick();
        drive_e(32'h0000_0080, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, MEM_W);
        #1;
        chk("b2b st addr", dmem_addr, 32'h0000_0040);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        nop();
        #1;
        chk("b2b ld req", {31'd0, dmem_req}, 32'd1);
        chk("b2b ld addr", dmem_addr, 32'h0000_0080);
        chk("b2b st alu_W", ALU_result_W, 32'h0000_0040);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        tick();
        dmem_rvalid = 1'b0;
        #1;
        chk("b2b ld rdata_W", read_data_W, 32'h1357_9BDF);
        chk("b2b ld rd_W", {27'd0, rd_W}, 32'd4);

        // Reset while waiting for rvalid.
        drive_e(32'h0000_0044, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, MEM_W);
        tick();
        nop();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("wait busy", {31'd0, mem_busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstw req", {31'd0, dmem_req}, 32'd0);
        chk("rstw busy", {31'd0, mem_busy}, 32'd0);
        chk("rstw alu_W", ALU_result_W, 32'd0);
        chk("rstw rdata_W", read_data_W, 32'd0);
        chk("rstw rd_W", {27'd0, rd_W}, 32'd0);
        chk("rstw rw_W", {31'd0, reg_write_W}, 32'd0);
        chk("rstw m2r_W", {31'd0, mem_to_reg_W}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        drive_e(32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, MEM_W);
        tick();
        nop();
        #1;
        chk("mis pulse", {31'd0, misalign_M}, 32'd1);
        chk("mis req", {31'd0, dmem_req}, 32'd0);
        tick();
        #1;
        chk("mis pulse end", {31'd0, misalign_M}, 32'd0);
        chk("mis req2", {31'd0, dmem_req}, 32'd0);
        chk("mis rw_W", {31'd0, reg_write_W}, 32'd0);
`else
        mis = '{32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, MEM_W, 32'hA5A5_0F0F, 4'b1111, 32'h0, 32'h0000_0100, 32'hA5A5_0F0F};
        run_vec(mis, "misLW");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
